// File: rtl/mat_xfer_engine.sv
// Matrix transfer engine: walks a rows x cols region row-major on one memory port
// doing pattern fill, constant fill, strided copy or transposing copy.
// Latency: fill 2 cycles/element, copy 3 + read latency cycles/element at full grant.
// Backpressure: the request stays held until mem_gnt; read data is awaited in RD_WAIT.
// Ports: clk/rst (sync, active-high); go + mode/geometry/fill_val config (latched on go);
//   mem_req/mem_write/mem_addr/mem_wdata request bus with mem_gnt accept;
//   mem_rdata_vld/mem_rdata read return; busy level and one-cycle done pulse.
module mat_xfer_engine #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DIM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [1:0]          mode,
  input  logic [MEM_AW-1:0]   src_base,
  input  logic [MEM_AW-1:0]   dst_base,
  input  logic [DIM_BITS-1:0] src_stride,
  input  logic [DIM_BITS-1:0] dst_stride,
  input  logic [DIM_BITS-1:0] rows,
  input  logic [DIM_BITS-1:0] cols,
  input  logic [MEM_DW-1:0]   fill_val,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rdata_vld,
  input  logic [MEM_DW-1:0]   mem_rdata,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_ADV, S_DONE
  } state_e;

  localparam logic [1:0] M_FILL_PAT   = 2'd0;
  localparam logic [1:0] M_FILL_CONST = 2'd1;
  localparam logic [1:0] M_COPY_T     = 2'd3;

  state_e              state_q, state_d;
  logic [1:0]          mode_q;
  logic [MEM_AW-1:0]   src_base_q, dst_base_q;
  logic [DIM_BITS-1:0] src_stride_q, dst_stride_q, rows_q, cols_q;
  logic [MEM_DW-1:0]   fill_q;
  logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d;
  logic [MEM_DW-1:0]   rdata_q, rdata_d;
  logic                req_q, req_d, write_q, write_d, busy_q, busy_d, done_q, done_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [MEM_DW-1:0]   wdata_q, wdata_d;

  logic                is_copy;
  logic                accept_go;
  logic [DIM_BITS-1:0] j_inc, i_inc;
  logic [MEM_AW-1:0]   src_addr, dst_addr;
  logic [MEM_DW-1:0]   pat_val;

  assign is_copy   = mode_q[1];
  assign accept_go = (state_q == S_IDLE) && go;
  assign j_inc     = j_q + DIM_BITS'(1);
  assign i_inc     = i_q + DIM_BITS'(1);

  // Next-state and index walk.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_CHECK;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_CHECK: begin
        if (rows_q == '0 || cols_q == '0) state_d = S_DONE;
        else                              state_d = is_copy ? S_RD_REQ : S_WR_REQ;
      end
      S_RD_REQ:  if (mem_gnt) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        // Only the first valid beat while waiting is taken.
        if (mem_rdata_vld) begin
          rdata_d = mem_rdata;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ:  if (mem_gnt) state_d = S_ADV;
      S_ADV: begin
        if (j_inc == cols_q) begin
          j_d = '0;
          i_d = i_inc;
        end else begin
          j_d = j_inc;
        end
        if (i_d == rows_q) state_d = S_DONE;
        else               state_d = is_copy ? S_RD_REQ : S_WR_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are computed from the next indices so the registered bus
  // presents the new element in the very cycle the request state is entered.
  always_comb begin
    src_addr = src_base_q + MEM_AW'(src_stride_q) * MEM_AW'(i_d) + MEM_AW'(j_d);
    if (mode_q == M_COPY_T)
      dst_addr = dst_base_q + MEM_AW'(dst_stride_q) * MEM_AW'(j_d) + MEM_AW'(i_d);
    else
      dst_addr = dst_base_q + MEM_AW'(dst_stride_q) * MEM_AW'(i_d) + MEM_AW'(j_d);
    pat_val = ~(MEM_DW'(i_d) + MEM_DW'(j_d) + MEM_DW'(1));

    req_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    write_d = (state_d == S_WR_REQ);
    addr_d  = '0;
    wdata_d = '0;
    if (state_d == S_RD_REQ) begin
      addr_d = src_addr;
    end else if (state_d == S_WR_REQ) begin
      addr_d = dst_addr;
      if (mode_q == M_FILL_PAT)        wdata_d = pat_val;
      else if (mode_q == M_FILL_CONST) wdata_d = fill_q;
      else                             wdata_d = rdata_d;
    end
    busy_d = (state_d == S_CHECK) || (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
             (state_d == S_WR_REQ) || (state_d == S_ADV);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      src_stride_q <= '0;
      dst_stride_q <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      fill_q       <= '0;
      i_q          <= '0;
      j_q          <= '0;
      rdata_q      <= '0;
      req_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept_go) begin
        mode_q       <= mode;
        src_base_q   <= src_base;
        dst_base_q   <= dst_base;
        src_stride_q <= src_stride;
        dst_stride_q <= dst_stride;
        rows_q       <= rows;
        cols_q       <= cols;
        fill_q       <= fill_val;
      end
    end
  end

  assign mem_req   = req_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mat_xfer_engine.sv
// Bench for mat_xfer_engine: randomized memory responder plus a row-major
// reference model of the expected request stream, compared transaction by transaction.
module tb_mat_xfer_engine;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DB = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, go;
  logic [1:0]    mode;
  logic [AW-1:0] src_base, dst_base;
  logic [DB-1:0] src_stride, dst_stride, rows, cols;
  logic [DW-1:0] fill_val;
  logic          mem_req, mem_write, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt       = 1'b0;
  logic          mem_rdata_vld = 1'b0;
  logic [DW-1:0] mem_rdata     = '0;

  mat_xfer_engine #(.MEM_AW(AW), .MEM_DW(DW), .DIM_BITS(DB)) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode),
    .src_base(src_base), .dst_base(dst_base),
    .src_stride(src_stride), .dst_stride(dst_stride),
    .rows(rows), .cols(cols), .fill_val(fill_val),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Responder configuration (written by the stimulus only between runs).
  int            gnt_pct = 100;
  int            rd_lat  = 1;
  bit            spur_en = 1'b0;
  logic [DW-1:0] salt    = '0;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return 32'hA0 + DW'(a) + salt;
  endfunction

  // Memory responder / monitor; everything it writes is owned by it alone.
  txn_t          obs_q[$];
  int            done_cnt = 0;
  int            req_idle_cnt = 0;
  int            hold_err = 0;
  bit            stall = 1'b0;
  txn_t          stall_t;
  bit            rd_pend = 1'b0;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      mem_gnt       = 1'b0;
      mem_rdata_vld = 1'b0;
      rd_pend       = 1'b0;
      stall         = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (mem_req && !busy) req_idle_cnt++;
      if (stall && (!mem_req || {mem_write, mem_addr, mem_wdata} !== stall_t)) hold_err++;
      mem_rdata_vld = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_rdata_vld = 1'b1;
          mem_rdata     = rd_fn(rd_addr);
          rd_pend       = 1'b0;
        end else begin
          rd_cnt--;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        mem_rdata_vld = 1'b1;
        mem_rdata     = $urandom;
      end
      mem_gnt = ($urandom_range(1, 100) <= gnt_pct);
      stall   = 1'b0;
      if (mem_req) begin
        if (mem_gnt) begin
          obs_q.push_back({mem_write, mem_addr, mem_wdata});
          if (!mem_write) begin
            rd_pend = 1'b1;
            rd_cnt  = rd_lat - 1;
            rd_addr = mem_addr;
          end
        end else begin
          stall   = 1'b1;
          stall_t = {mem_write, mem_addr, mem_wdata};
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   mem_req,   0);
    check({tag, "_write"}, mem_write, 0);
    check({tag, "_addr"},  mem_addr,  0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
  endtask

  // One complete transfer: build the expected stream, drive go, scramble the
  // config while busy, poke go while busy and in the done cycle, then compare.
  task automatic run(input logic [1:0] m, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                     input logic [DB-1:0] ss, input logic [DB-1:0] ds,
                     input logic [DB-1:0] r, input logic [DB-1:0] c,
                     input logic [DW-1:0] fv, input string tag,
                     output int lat_cyc, output int base);
    txn_t exp_q[$];
    int   done0, idle0, hold0, nw;
    bit   got;
    for (int i = 0; i < int'(r); i++) begin
      for (int j = 0; j < int'(c); j++) begin
        logic [AW-1:0] sa, da;
        logic [DW-1:0] d, t;
        sa = AW'(int'(sb) + int'(ss) * i + j);
        if (m == 2'd3) da = AW'(int'(db) + int'(ds) * j + i);
        else           da = AW'(int'(db) + int'(ds) * i + j);
        t = DW'(i + j + 1);
        if (m == 2'd0)      d = ~t;
        else if (m == 2'd1) d = fv;
        else                d = rd_fn(sa);
        if (m[1]) exp_q.push_back({1'b0, sa, DW'(0)});
        exp_q.push_back({1'b1, da, d});
      end
    end
    base  = obs_q.size();
    done0 = done_cnt;
    idle0 = req_idle_cnt;
    hold0 = hold_err;
    @(negedge clk);
    mode = m; src_base = sb; dst_base = db; src_stride = ss; dst_stride = ds;
    rows = r; cols = c; fill_val = fv; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    mode = 2'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom);
    src_stride = DB'($urandom); dst_stride = DB'($urandom);
    rows = DB'($urandom_range(0, 3)); cols = DB'($urandom_range(0, 3)); fill_val = $urandom;
    lat_cyc = 0;
    got     = 1'b0;
    while (lat_cyc < 5000) begin
      @(negedge clk);
      lat_cyc++;
      go = (lat_cyc == 3) && busy;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    go = 1'b1;  // lands in the done cycle and must be ignored
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_done_once"}, done_cnt - done0, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_req_outside_busy"}, req_idle_cnt - idle0, 0);
    check({tag, "_held_while_stalled"}, hold_err - hold0, 0);
    check({tag, "_n_txn"}, obs_q.size() - base, exp_q.size());
    nw = (obs_q.size() - base < exp_q.size()) ? obs_q.size() - base : exp_q.size();
    for (int k = 0; k < nw; k++) begin
      check($sformatf("%s_t%0d_write", tag, k), obs_q[base+k].w, exp_q[k].w);
      check($sformatf("%s_t%0d_addr", tag, k),  obs_q[base+k].a, exp_q[k].a);
      if (exp_q[k].w)
        check($sformatf("%s_t%0d_data", tag, k), obs_q[base+k].d, exp_q[k].d);
    end
  endtask

  int lc, b, n;

  initial begin
    rst = 1'b1; go = 1'b0; mode = '0; src_base = '0; dst_base = '0;
    src_stride = '0; dst_stride = '0; rows = '0; cols = '0; fill_val = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Pattern fill, full grant: 2 cycles per element after the check cycle.
    run(2'd0, 16'h0, 16'h100, 16'd0, 16'd4, 16'd2, 16'd3, 32'h0, "fillpat", lc, b);
    check("fillpat_cycles", lc, 13);
    if (obs_q.size() >= b + 6) begin
      check("fillpat_w3_addr", obs_q[b+3].a, 16'h104);
      check("fillpat_w5_data", obs_q[b+5].d, 32'hFFFF_FFFB);
    end

    // Copy with read data two cycles after grant.
    rd_lat = 2;
    run(2'd2, 16'h0, 16'h200, 16'd2, 16'd8, 16'd2, 16'd2, 32'h0, "copy", lc, b);
    if (obs_q.size() >= b + 8) begin
      check("copy_w2_addr", obs_q[b+5].a, 16'h208);
      check("copy_w2_data", obs_q[b+5].d, 32'hA2);
      check("copy_w3_addr", obs_q[b+7].a, 16'h209);
      check("copy_w3_data", obs_q[b+7].d, 32'hA3);
    end

    // Transposing copy: element (1,2) lands at dst_base + 2*2 + 1.
    rd_lat = 1; salt = $urandom;
    run(2'd3, 16'h40, 16'h300, 16'd3, 16'd2, 16'd2, 16'd3, 32'h0, "copyt", lc, b);
    if (obs_q.size() >= b + 12) check("copyt_elem12_addr", obs_q[b+11].a, 16'h305);

    // Sparse grants with stray read-valid pulses.
    gnt_pct = 30; spur_en = 1'b1;
    run(2'd1, 16'h0, 16'hFFFE, 16'd0, 16'd3, 16'd3, 16'd2, 32'hDEAD_BEEF, "const30", lc, b);
    rd_lat = 3;
    run(2'd2, 16'hFFF0, 16'h500, 16'd1, 16'd5, 16'd3, 16'd3, 32'h0, "copy30", lc, b);
    run(2'd0, 16'h0, 16'h80, 16'd4, 16'd4, 16'd2, 16'd3, 32'h0, "fillpat30", lc, b);

    // Empty regions.
    gnt_pct = 100; rd_lat = 1;
    run(2'd0, 16'h0, 16'h100, 16'd0, 16'd4, 16'd0, 16'd5, 32'h0, "rows0", lc, b);
    check("rows0_latency", lc, 1);
    run(2'd2, 16'h0, 16'h100, 16'd0, 16'd4, 16'd3, 16'd0, 32'h0, "cols0", lc, b);
    check("cols0_latency", lc, 1);

    // Abort mid-transfer after the third write grant.
    spur_en = 1'b0;
    b  = obs_q.size();
    n  = done_cnt;
    @(negedge clk);
    mode = 2'd0; dst_base = 16'h700; dst_stride = 16'd3; rows = 16'd3; cols = 16'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    lc = 0;
    while (obs_q.size() < b + 3 && lc < 200) begin
      @(negedge clk);
      #1;
      lc++;
    end
    check("abort_third_write_seen", obs_q.size() >= b + 3, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - n, 0);
    check("abort_no_more_txn", obs_q.size() - b, 3);
    run(2'd0, 16'h0, 16'h20, 16'd0, 16'd2, 16'd2, 16'd2, 32'h0, "after_abort", lc, b);
    check("after_abort_cycles", lc, 9);

    // Randomized configurations, some strides large enough to wrap the address.
    for (int t = 0; t < 10; t++) begin
      gnt_pct = $urandom_range(30, 100);
      rd_lat  = $urandom_range(1, 4);
      spur_en = 1'b1;
      salt    = $urandom;
      run(2'($urandom), AW'($urandom), AW'($urandom),
          ($urandom_range(0, 1) == 1) ? DB'($urandom) : DB'($urandom_range(0, 6)),
          ($urandom_range(0, 1) == 1) ? DB'($urandom) : DB'($urandom_range(0, 6)),
          DB'($urandom_range(0, 4)), DB'($urandom_range(0, 4)), $urandom,
          $sformatf("rnd%0d", t), lc, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
